// File: rtl/serial_subtractor_n_bit_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_subtractor_n_bit_pkg;

  // Control states of a bit-serial operator: waiting for operands,
  // shifting bits through the cell, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Bit counter width large enough to hold 0..w without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_n_bit_cell.sv
// Single-bit full subtractor used as the serial datapath cell.
module full_subtractor_1_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference and borrow of a - b - bin for one bit position.
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial N-bit subtractor: accepts operands in IDLE, processes one bit
// per cycle LSB-first in BUSY, holds the result in DONE until consumed.
module serial_subtractor_n_bit
  import serial_subtractor_n_bit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cell_diff;
  logic             cell_bout;

  // One cell, fed from the operand LSBs and the running borrow each cycle.
  full_subtractor_1_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // Handshake flags decode straight from state, so no input reaches them.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign bout      = br_q;

  // Next-state and datapath update: load on accept, shift in BUSY, hold otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = cell_bout;
        // Shift-then-overwrite keeps this legal for WIDTH == 1.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_diff;
        cnt_d            = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Self-checking bench for serial_subtractor_n_bit at WIDTH = 4.
module tb_serial_subtractor_n_bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  serial_subtractor_n_bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int bin;
    int exp_diff;
    int exp_bout;
    int stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic int ref_diff(input int av, input int bv, input int bi);
    int r;
    r = av - bv - bi;
    return r & ((1 << W) - 1);
  endfunction

  function automatic int ref_bout(input int av, input int bv, input int bi);
    return (av < bv + bi) ? 1 : 0;
  endfunction

  // One full transaction; assumes the bench is #1 after a rising edge.
  task automatic run_op(input int ta, input int tb_v, input int tbi,
                        input int stall, input int ed, input int eb,
                        input string tag);
    int n;
    int lat;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 4 * W + 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk({tag, " ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    a = W'(ta); b = W'(tb_v); bin = tbi[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, " accepted"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < W + 8) begin
      // Noise on every input while busy; all of it must be ignored.
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(W));
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold_diff"}, 32'(diff), 32'(ed));
      chk({tag, " hold_bout"}, 32'(bout), 32'(eb));
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " kept_diff"}, 32'(diff), 32'(ed));
    chk({tag, " kept_bout"}, 32'(bout), 32'(eb));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int ra, rb, rc;
    tbl[0] = '{a: 9,  b: 3,  bin: 0, exp_diff: 6,  exp_bout: 0, stall: 0};
    tbl[1] = '{a: 3,  b: 9,  bin: 0, exp_diff: 10, exp_bout: 1, stall: 0};
    tbl[2] = '{a: 0,  b: 0,  bin: 1, exp_diff: 15, exp_bout: 1, stall: 0};
    tbl[3] = '{a: 15, b: 15, bin: 0, exp_diff: 0,  exp_bout: 0, stall: 0};
    tbl[4] = '{a: 15, b: 0,  bin: 0, exp_diff: 15, exp_bout: 0, stall: 0};
    tbl[5] = '{a: 9,  b: 3,  bin: 0, exp_diff: 6,  exp_bout: 0, stall: 5};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst diff", 32'(diff), 32'd0);
    chk("rst bout", 32'(bout), 32'd0);
    rst = 1'b0;

    // Directed vectors, including a 5-cycle backpressure case.
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].stall,
             tbl[i].exp_diff, tbl[i].exp_bout, $sformatf("vec%0d", i));
    end

    // Reset two cycles into an operation.
    a = W'(9); b = W'(3); bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst diff", 32'(diff), 32'd0);
    chk("midrst bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      chk("midrst no_result", 32'(out_valid), 32'd0);
    end
    run_op(5, 7, 1, 0, 13, 1, "post_rst");

    // Exhaustive at maximum issue rate against the reference.
    for (int ai = 0; ai < (1 << W); ai++) begin
      for (int bi = 0; bi < (1 << W); bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          run_op(ai, bi, ci, 0, ref_diff(ai, bi, ci), ref_bout(ai, bi, ci),
                 $sformatf("exh a=%0d b=%0d bin=%0d", ai, bi, ci));
        end
      end
    end

    // Random operands with random consumer stalls.
    for (int k = 0; k < 150; k++) begin
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      rc = int'($urandom_range(0, 1));
      run_op(ra, rb, rc, int'($urandom_range(0, 3)),
             ref_diff(ra, rb, rc), ref_bout(ra, rb, rc),
             $sformatf("rnd a=%0d b=%0d bin=%0d", ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
